// File: rtl/poseidon_frame_pkg.sv
// -----------------------------------------------------------------------------
// poseidon_frame_pkg
// Shared constants and types for the Poseidon framing stage:
//   DATA_WIDTH  - field element width (255)
//   STATE_SIZE  - beats per output frame (domain tag + 8 rate elements)
//   DOMAIN_TAG  - constant emitted as beat 0 of every frame
//   state_t     - framing FSM states (TAG, DATA, PAD, DROP)
// -----------------------------------------------------------------------------
package poseidon_frame_pkg;

   localparam int DATA_WIDTH = 255;
   localparam int STATE_SIZE = 9;
   localparam int BEAT_W     = 4;

   localparam logic [DATA_WIDTH-1:0] DOMAIN_TAG =
      255'hc59041b7aa57a3757c9e652d111ec48d5f04d67039bae3300000232fffffdcd;

   // Index of the final beat of a frame; io_output_last is asserted here only.
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(STATE_SIZE - 1);

   typedef enum logic [1:0] {
      ST_TAG  = 2'd0,
      ST_DATA = 2'd1,
      ST_PAD  = 2'd2,
      ST_DROP = 2'd3
   } state_t;

endpackage

// File: rtl/poseidon_frame_builder_if.sv
// -----------------------------------------------------------------------------
// poseidon_frame_builder_if
// Message-in / frame-out stream bundle of the framing stage.
//   io_input_*  : message elements (valid, ready, last, payload)
//   io_output_* : frame beats towards the Poseidon core (valid, ready, last,
//                 payload)
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid & ready are both high; a source that raised valid keeps valid,
// payload and last unchanged until that transfer; ready may change freely.
// Modports:
//   slave  - the frame builder's view (consumes input, produces output)
//   master - the environment's view (produces input, consumes output)
// -----------------------------------------------------------------------------
interface poseidon_frame_builder_if;
   import poseidon_frame_pkg::*;

   logic                  io_input_valid;
   logic                  io_input_ready;
   logic                  io_input_last;
   logic [DATA_WIDTH-1:0] io_input_payload;

   logic                  io_output_valid;
   logic                  io_output_ready;
   logic                  io_output_last;
   logic [DATA_WIDTH-1:0] io_output_payload;

   modport slave (
      input  io_input_valid, io_input_last, io_input_payload, io_output_ready,
      output io_input_ready, io_output_valid, io_output_last, io_output_payload
   );

   modport master (
      output io_input_valid, io_input_last, io_input_payload, io_output_ready,
      input  io_input_ready, io_output_valid, io_output_last, io_output_payload
   );

endinterface

// File: rtl/poseidon_skid_buffer.sv
// -----------------------------------------------------------------------------
// poseidon_skid_buffer
// Two-entry skid buffer: fully registered valid/ready/data on both sides,
// full throughput, one cycle of latency.
//   clk, reset          - clock, synchronous active-high reset (empties buffer)
//   in_valid/in_ready   - upstream handshake, in_data W bits
//   out_valid/out_ready - downstream handshake, out_data W bits
// -----------------------------------------------------------------------------
module poseidon_skid_buffer #(
   parameter int W = 256
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         skid_valid;
   logic [W-1:0] skid_data;

   // Ready comes straight from a flop: no path from out_ready to in_ready.
   assign in_ready = ~skid_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (out_ready || !out_valid) begin
         // Output register free this cycle: refill from skid first, else
         // from the input (in_ready is high whenever skid is empty).
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_valid;
            out_data  <= in_data;
         end
      end else if (in_valid && !skid_valid) begin
         // Output stalled: park the word accepted this cycle.
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/poseidon_frame_builder.sv
// -----------------------------------------------------------------------------
// poseidon_frame_builder
// Turns 1..8-element messages into fixed 9-beat frames for the Poseidon core:
// domain tag, message elements, zero padding. Elements beyond the 8th are
// discarded and flagged in a sticky overflow bit.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   bus            - poseidon_frame_builder_if.slave (io_input_*, io_output_*)
//   io_frame_count - frames completed (last-beat output handshakes), wraps
//   io_overflow    - sticky, a message had more than 8 elements
//   dbg_state      - current FSM state
// Build option:
//   POSEIDON_FRAME_OUT_REG_EN - when defined, a 2-entry skid buffer registers
//   the output stream (+1 cycle latency, full throughput); otherwise the
//   output is a combinational passthrough.
// -----------------------------------------------------------------------------
module poseidon_frame_builder
   import poseidon_frame_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   poseidon_frame_builder_if.slave   bus,
   output logic [15:0]               io_frame_count,
   output logic                      io_overflow,
   output state_t                    dbg_state
);

   state_t                state, state_nxt;
   logic [BEAT_W-1:0]     beat, beat_nxt;
   logic                  ovf_set;

   // Frame stream as produced by the FSM, before the optional output register.
   logic                  core_valid;
   logic                  core_ready;
   logic                  core_last;
   logic [DATA_WIDTH-1:0] core_payload;
   logic                  in_ready_c;

   // Frame stream at the module boundary.
   logic                  out_valid;
   logic                  out_last;
   logic [DATA_WIDTH-1:0] out_payload;
   logic                  out_hs;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_TAG;
         beat  <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      beat_nxt     = beat;
      core_valid   = 1'b0;
      core_last    = 1'b0;
      core_payload = '0;
      in_ready_c   = 1'b0;
      ovf_set      = 1'b0;
      unique case (state)
         ST_TAG: begin
            // The tag goes out only once a message is waiting, without
            // consuming its first element.
            core_valid   = bus.io_input_valid;
            core_payload = DOMAIN_TAG;
            if (core_valid && core_ready) begin
               beat_nxt  = BEAT_W'(1);
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            core_valid   = bus.io_input_valid;
            core_payload = bus.io_input_payload;
            core_last    = (beat == LAST_BEAT);
            in_ready_c   = core_ready;
            if (core_valid && core_ready) begin
               if (beat == LAST_BEAT) begin
                  beat_nxt  = '0;
                  state_nxt = bus.io_input_last ? ST_TAG : ST_DROP;
                  ovf_set   = ~bus.io_input_last;
               end else begin
                  beat_nxt = beat + BEAT_W'(1);
                  if (bus.io_input_last) begin
                     state_nxt = ST_PAD;
                  end
               end
            end
         end
         ST_PAD: begin
            core_valid = 1'b1;
            core_last  = (beat == LAST_BEAT);
            if (core_ready) begin
               if (beat == LAST_BEAT) begin
                  beat_nxt  = '0;
                  state_nxt = ST_TAG;
               end else begin
                  beat_nxt = beat + BEAT_W'(1);
               end
            end
         end
         ST_DROP: begin
            // Swallow the rest of an oversized message.
            in_ready_c = 1'b1;
            if (bus.io_input_valid && bus.io_input_last) begin
               state_nxt = ST_TAG;
            end
         end
         default: begin
            state_nxt = ST_TAG;
            beat_nxt  = '0;
         end
      endcase
   end

`ifdef POSEIDON_FRAME_OUT_REG_EN
   poseidon_skid_buffer #(
      .W (DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (core_valid),
      .in_ready  (core_ready),
      .in_data   ({core_last, core_payload}),
      .out_valid (out_valid),
      .out_ready (bus.io_output_ready),
      .out_data  ({out_last, out_payload})
   );
`else
   assign core_ready  = bus.io_output_ready;
   assign out_valid   = core_valid;
   assign out_last    = core_last;
   assign out_payload = core_payload;
`endif

   // Handshake qualifiers are held low for the whole reset cycle.
   assign bus.io_output_valid   = out_valid & ~reset;
   assign bus.io_output_last    = out_last & ~reset;
   assign bus.io_output_payload = out_payload;
   assign bus.io_input_ready    = in_ready_c & ~reset;

   assign out_hs = bus.io_output_valid & bus.io_output_ready & bus.io_output_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         io_frame_count <= '0;
         io_overflow    <= 1'b0;
      end else begin
         if (out_hs) begin
            io_frame_count <= io_frame_count + 16'd1;
         end
         if (ovf_set && core_valid && core_ready) begin
            io_overflow <= 1'b1;
         end
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_poseidon_frame_builder.sv
module tb_poseidon_frame_builder;
   import poseidon_frame_pkg::*;

   localparam int W = DATA_WIDTH;
   typedef logic [W:0] word_t;   // {last, payload}

`ifdef POSEIDON_FRAME_OUT_REG_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   poseidon_frame_builder_if bus();
   logic [15:0] io_frame_count;
   logic        io_overflow;
   state_t      dbg_state;

   poseidon_frame_builder dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .io_frame_count (io_frame_count),
      .io_overflow    (io_overflow),
      .dbg_state      (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   word_t       exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] model_fc = '0;
   logic        model_ovf = 1'b0;
   bit          bp_en = 1'b0;
   int          cyc = 0;
   int          mon_idx = 0;
   int          tag_cyc = 0;
   int          frame_span = 0;
   int          start_cyc = 0;
   bit          prev_stall = 1'b0;
   word_t       prev_beat = '0;

   task automatic check(input string tag, input word_t obs, input word_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: a message of n elements yields tag, the first
   // min(n,8) elements, zeros up to 9 beats; last on beat 9 only.
   function automatic void model_msg(input logic [W-1:0] m[$]);
      logic [W-1:0] v;
      exp_q.push_back({1'b0, DOMAIN_TAG});
      for (int i = 1; i < STATE_SIZE; i++) begin
         v = (i <= m.size()) ? m[i-1] : '0;
         exp_q.push_back({(i == STATE_SIZE - 1), v});
      end
      model_fc = model_fc + 16'd1;
      if (m.size() > STATE_SIZE - 1) model_ovf = 1'b1;
   endfunction

   function automatic logic [W-1:0] rand_elem();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r[W-1:0];
   endfunction

   // ---------------- downstream ready driver ----------------
   initial begin
      bus.io_output_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.io_output_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      word_t cur;
      word_t e;
      cyc++;
      cur = {bus.io_output_last, bus.io_output_payload};
      if (!reset) begin
         if (prev_stall) begin
            check("hold_valid", word_t'(bus.io_output_valid), word_t'(1));
            check("hold_beat", cur, prev_beat);
         end
         if (dbg_state == ST_TAG || dbg_state == ST_PAD)
            check("ready_low_tag_pad", word_t'(bus.io_input_ready), word_t'(0));
         if (dbg_state == ST_DROP)
            check("ready_high_drop", word_t'(bus.io_input_ready), word_t'(1));
         if (bus.io_output_valid && bus.io_output_ready) begin
            check("beat_expected", word_t'(exp_q.size() != 0), word_t'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("beat", cur, e);
            end
            if (mon_idx == 0) tag_cyc = cyc;
            if (mon_idx == STATE_SIZE - 1) begin
               frame_span = cyc - tag_cyc;
               mon_idx = 0;
            end else begin
               mon_idx++;
            end
         end
         prev_stall = bus.io_output_valid && !bus.io_output_ready;
         prev_beat  = cur;
      end else begin
         prev_stall = 1'b0;
         mon_idx    = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_elem(input logic [W-1:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      bus.io_input_valid   = 1'b1;
      bus.io_input_payload = d;
      bus.io_input_last    = l;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (bus.io_input_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("input_accept", word_t'(ok), word_t'(1));
      @(posedge clk);
      #1;
      bus.io_input_valid = 1'b0;
      bus.io_input_last  = 1'b0;
   endtask

   task automatic send_msg(input int n, input bit gaps);
      logic [W-1:0] m[$];
      for (int i = 0; i < n; i++) m.push_back(rand_elem());
      model_msg(m);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_elem(m[i], i == n - 1);
      end
   endtask

   task automatic wait_empty();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", word_t'(ok), word_t'(1));
   endtask

   task automatic drain_and_check(input string tag);
      wait_empty();
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_frame_count"}, word_t'(io_frame_count), word_t'(model_fc));
      check({tag, "_overflow"}, word_t'(io_overflow), word_t'(model_ovf));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [W-1:0] e;
      bus.io_input_valid   = 1'b0;
      bus.io_input_last    = 1'b0;
      bus.io_input_payload = '0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", word_t'(bus.io_output_valid), word_t'(0));
      check("rst_in_ready", word_t'(bus.io_input_ready), word_t'(0));
      check("rst_out_last", word_t'(bus.io_output_last), word_t'(0));
      check("rst_frame_count", word_t'(io_frame_count), word_t'(0));
      check("rst_overflow", word_t'(io_overflow), word_t'(0));
      check("rst_state", word_t'(dbg_state), word_t'(ST_TAG));
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Full 8-element message, no back-pressure: latency and 9 back-to-back beats
      start_cyc = cyc + 1;
      send_msg(8, 1'b0);
      drain_and_check("full8");
      check("tag_latency", word_t'(tag_cyc - start_cyc), word_t'(EXP_LAT));
      check("full8_span", word_t'(frame_span), word_t'(STATE_SIZE - 1));

      // Short message with padding
      send_msg(3, 1'b0);
      drain_and_check("short3");
      check("short3_span", word_t'(frame_span), word_t'(STATE_SIZE - 1));

      // Oversized message then a single element
      send_msg(10, 1'b0);
      send_msg(1, 1'b0);
      drain_and_check("ovf10");

      // Random back-pressure and input gaps
      bp_en = 1'b1;
      for (int k = 0; k < 3; k++) send_msg($urandom_range(1, 10), 1'b1);
      drain_and_check("random_bp");
      for (int k = 0; k < 3; k++) send_msg($urandom_range(1, 8), 1'b1);
      drain_and_check("random_bp2");
      bp_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset at beat 4 of a frame
      exp_q.push_back({1'b0, DOMAIN_TAG});
      for (int i = 0; i < 3; i++) begin
         e = rand_elem();
         exp_q.push_back({1'b0, e});
         send_elem(e, 1'b0);
      end
      wait_empty();
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.io_input_valid   = 1'b1;
      bus.io_input_payload = rand_elem();
      @(negedge clk);
      check("midrst_out_valid", word_t'(bus.io_output_valid), word_t'(0));
      check("midrst_in_ready", word_t'(bus.io_input_ready), word_t'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("midrst_out_valid2", word_t'(bus.io_output_valid), word_t'(0));
      check("midrst_out_last", word_t'(bus.io_output_last), word_t'(0));
      check("midrst_frame_count", word_t'(io_frame_count), word_t'(0));
      check("midrst_overflow", word_t'(io_overflow), word_t'(0));
      check("midrst_state", word_t'(dbg_state), word_t'(ST_TAG));
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.io_input_valid = 1'b0;
      model_fc  = '0;
      model_ovf = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("postrst_frame_count", word_t'(io_frame_count), word_t'(0));
      check("postrst_out_valid", word_t'(bus.io_output_valid), word_t'(0));
      @(posedge clk);
      #1;
      send_msg(8, 1'b0);
      drain_and_check("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/poseidon_frame_builder.md
# poseidon_frame_builder

Upstream framing stage for the Poseidon hash core. It accepts a variable-length message stream of 255-bit field elements, 1 to 8 elements per message with a `last` marker. It emits fixed 9-beat frames: a domain-tag element, the message elements, then zero padding. The output feeds `PoseidonTopLevel` directly, which expects `io_input_last` on the 9th beat of every frame.

## Interface
- `DATA_WIDTH`, 255, field-element width.
- `STATE_SIZE`, 9, beats per output frame (tag + 8 rate elements).
- `DOMAIN_TAG`, 255'hc59041b7aa57a3757c9e652d111ec48d5f04d67039bae3300000232fffffdcd, constant emitted as beat 0.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_input_valid`  in  1  message element valid.
- `io_input_ready`  out  1  message element accepted when valid & ready.
- `io_input_last`  in  1  final element of the message.
- `io_input_payload`  in  DATA_WIDTH  message element.
- `io_output_valid`  out  1  frame beat valid.
- `io_output_ready`  in  1  downstream (Poseidon core) ready.
- `io_output_last`  out  1  high on beat index STATE_SIZE-1 only.
- `io_output_payload`  out  DATA_WIDTH  frame beat.
- `io_frame_count`  out  16  frames completed (last-beat handshakes), wraps 0xFFFF->0.
- `io_overflow`  out  1  sticky: a message exceeded STATE_SIZE-1 elements.

## Operation
- Beat counter `beat` is 0..STATE_SIZE-1. The FSM has states TAG, DATA, PAD and DROP.
- TAG:
  - `io_output_valid = io_input_valid`; payload is DOMAIN_TAG; `io_input_ready = 0`. No input is consumed.
  - On output handshake: beat=1, go to DATA.
- DATA: passthrough, with `io_output_valid = io_input_valid`, `io_input_ready = io_output_ready`, payload = input.
  - Handshake with input last and beat<8: beat++, go to PAD.
  - Handshake at beat 8 with input last: output last, frame_count++, beat=0, go to TAG.
  - Handshake at beat 8 without input last: output last, frame_count++, overflow<=1, go to DROP.
  - Otherwise: beat++.
- PAD: `io_output_valid = 1`, payload is 0, `io_input_ready = 0`. On handshake beat++; at beat 8 assert last, frame_count++, go to TAG.
- DROP: `io_input_ready = 1`, `io_output_valid = 0`. Excess elements are discarded. On an input handshake with last, go to TAG.
- Message ending exactly on beat 8: no PAD beats.
- `io_overflow` clears only on reset.

## Timing
- Reset values: FSM=TAG, beat=0, io_output_valid=0, io_input_ready=0, io_output_last=0, io_frame_count=0, io_overflow=0. Valid/ready are forced low while `reset` is high.
- Reset mid-frame abandons the partial frame. The next frame restarts at TAG and no partial beats are replayed.
- Without the output register: zero-cycle latency input->output in DATA. The tag beat costs one output cycle. An 8-element message occupies 9 output cycles.
- While valid & !ready, `io_output_payload` and `io_output_last` hold stable (the upstream AXI-style rule applies in DATA; internally generated beats are stable by construction).
- The counter is updated on the clock edge of the last-beat handshake, so `io_frame_count` is visible the next cycle.

## Configuration
- `POSEIDON_FRAME_OUT_REG_EN`, when defined: inserts a 2-entry skid buffer on the output.
  - Adds 1 cycle of latency and keeps full throughput.
  - `io_input_ready` and `io_output_*` become fully registered, with no combinational path from `io_output_ready` to `io_input_ready`.
  - The buffer is emptied on reset.
- Not defined: combinational passthrough as described above.

## Structure
- Package `poseidon_frame_pkg`: DATA_WIDTH, STATE_SIZE, DOMAIN_TAG constant, and the FSM state enum (TAG, DATA, PAD, DROP).
- Sub-module `poseidon_skid_buffer` (DATA_WIDTH+1 bits: payload + last), instantiated only under POSEIDON_FRAME_OUT_REG_EN.

## Test plan
- 8-element message e1..e8, output_ready=1 -> 9 beats: DOMAIN_TAG, e1..e8, last only on beat 9; frame_count=1.
- 3-element message -> DOMAIN_TAG, e1, e2, e3, then 5 zero beats; input_ready=0 throughout PAD; last on beat 9.
- 10-element message e1..e10 then 1-element message f1 -> frame DOMAIN_TAG, e1..e8 with overflow=1; e9 and e10 are dropped; the next frame is DOMAIN_TAG, f1, 7 zeros; frame_count=2.
- Random output_ready back-pressure (~50%) over 3 messages -> output beats are identical to the no-back-pressure run; payload stable during every valid & !ready cycle.
- Reset pulsed at beat 4 of a frame -> all outputs take their reset values; the next message yields a full frame starting with DOMAIN_TAG; frame_count=0 before that frame.
- With POSEIDON_FRAME_OUT_REG_EN defined -> the same beat sequences as the first two scenarios, each beat one cycle later, with sustained 1 beat/cycle.
